// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo_if: valid/ready word handshake between producer and UART TX.
// Revision 1.0
// ============================================================================
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo: FIFO-buffered UART transmitter, LSB first, optional parity.
// Revision 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  uart_tx_fifo_if.slave                 bus,
  output logic                          tx_busy_o,
  output logic                          tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          tx_o
);
  localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic             ODD_PAR    = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W:0]       count_q;
  logic [PTR_W:0]       count_d;

  state_t               state_q;
  logic [CNT_W-1:0]     clk_cnt_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_frame_end;
  logic [DATA_BITS-1:0] w_head;

  // Ready looks at full only, so a same-edge pop never frees a slot early.
  assign bus.tx_ready = (count_q != FULL_COUNT);
  assign w_push       = bus.tx_valid && bus.tx_ready;
  assign w_bit_end    = (clk_cnt_q == BIT_LAST);
  assign w_frame_end  = (state_q == S_STOP) && w_bit_end && (bit_cnt_q == STOP_LAST);
  assign w_pop        = (count_q != '0) && ((state_q == S_IDLE) || w_frame_end);
  assign w_head       = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + COUNT_ONE;
    end else if (w_pop && !w_push) begin
      count_d = count_q - COUNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= bus.tx_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      clk_cnt_q <= (state_q == S_IDLE || w_bit_end) ? '0 : clk_cnt_q + CNT_ONE;
      unique case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (w_pop) begin
            state_q  <= S_START;
            shift_q  <= w_head;
            parity_q <= (^w_head) ^ ODD_PAR;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (bit_cnt_q == STOP_LAST) begin
              done_q <= 1'b1;
              // A queued word starts straight away so the line never idles between frames.
              if (w_pop) begin
                state_q  <= S_START;
                shift_q  <= w_head;
                parity_q <= (^w_head) ^ ODD_PAR;
                tx_q     <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_o         = tx_q;
  assign tx_busy_o    = busy_q;
  assign tx_done_o    = done_q;
  assign fifo_count_o = count_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_fifo: four configurations (8N1, 8E1, 8O1, 5N2) against a frame model.
// Revision 1.0
// ============================================================================
module tb_uart_tx_fifo;
  localparam int BC = 10;
  localparam int NU = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       valid_drv [NU];
  logic [8:0] data_drv  [NU];
  logic       ready_w   [NU];
  logic       busy_w    [NU];
  logic       done_w    [NU];
  logic       tx_w      [NU];
  logic [2:0] cnt_w     [NU];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit check_en    = 1'b0;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    localparam int DB  = (g == 3) ? 5 : 8;
    localparam int PAR = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
    localparam int SB  = (g == 3) ? 2 : 1;

    uart_tx_fifo_if #(.DATA_BITS(DB)) bus ();
    assign bus.tx_data  = data_drv[g][DB-1:0];
    assign bus.tx_valid = valid_drv[g];
    assign ready_w[g]   = bus.tx_ready;

    uart_tx_fifo #(
      .CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(DB),
      .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(4)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus.slave),
      .tx_busy_o   (busy_w[g]),
      .tx_done_o   (done_w[g]),
      .fifo_count_o(cnt_w[g]),
      .tx_o        (tx_w[g])
    );
  end

  function automatic int cfg_db(input int u);
    return (u == 3) ? 5 : 8;
  endfunction
  function automatic int cfg_par(input int u);
    return (u == 1) ? 1 : ((u == 2) ? 2 : 0);
  endfunction
  function automatic int cfg_sb(input int u);
    return (u == 3) ? 2 : 1;
  endfunction
  function automatic int frame_len(input int u);
    return (1 + cfg_db(u) + ((cfg_par(u) != 0) ? 1 : 0) + cfg_sb(u)) * BC;
  endfunction

  // Frame model: a word queue plus a position counter inside the current frame.
  int mq [NU][64];
  int mh [NU];
  int mt [NU];
  int mpos [NU];
  int mword [NU];
  bit mbusy [NU];
  bit mdone [NU];

  task automatic model_step();
    for (int u = 0; u < NU; u++) begin
      int n;
      bit endf;
      bit push;
      if (rst) begin
        mh[u] = 0; mt[u] = 0; mpos[u] = 0; mbusy[u] = 1'b0; mdone[u] = 1'b0;
      end else begin
        n    = mt[u] - mh[u];
        push = valid_drv[u] && (n != 4);
        endf = mbusy[u] && (mpos[u] == frame_len(u) - 1);
        mdone[u] = endf;
        if (mbusy[u] && !endf) begin
          mpos[u]++;
        end else if (n > 0) begin
          mword[u] = mq[u][mh[u] % 64];
          mh[u]++;
          mbusy[u] = 1'b1;
          mpos[u]  = 0;
        end else begin
          mbusy[u] = 1'b0;
        end
        if (push) begin
          mq[u][mt[u] % 64] = int'(data_drv[u]) & ((1 << cfg_db(u)) - 1);
          mt[u]++;
        end
      end
    end
  endtask

  function automatic logic exp_tx(input int u);
    int b;
    if (!mbusy[u]) return 1'b1;
    b = mpos[u] / BC;
    if (b == 0) return 1'b0;
    if (b <= cfg_db(u)) return 1'((mword[u] >> (b - 1)) & 1);
    if (cfg_par(u) != 0 && b == cfg_db(u) + 1)
      return 1'(($countones(mword[u]) + ((cfg_par(u) == 2) ? 1 : 0)) % 2);
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      for (int u = 0; u < NU; u++) begin
        int n;
        logic [6:0] e;
        logic [6:0] a;
        n = mt[u] - mh[u];
        e = {exp_tx(u), mbusy[u], mdone[u], 3'(n), (n != 4)};
        a = {tx_w[u], busy_w[u], done_w[u], cnt_w[u], ready_w[u]};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL model unit%0d cyc=%0d: tx,busy,done,cnt,ready got %b required %b", u, cyc, a, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic frame_check(input int u, input logic [8:0] word, input logic [15:0] exp_bits,
                             input int nbits, input string nm);
    valid_drv[u] = 1'b1;
    data_drv[u]  = word;
    tick();
    valid_drv[u] = 1'b0;
    chk({nm, "_cnt_after_push"}, int'(cnt_w[u]), 1);
    chk({nm, "_tx_idle_after_push"}, int'(tx_w[u]), 1);
    tick();
    chk({nm, "_start_tx"}, int'(tx_w[u]), 0);
    chk({nm, "_start_busy"}, int'(busy_w[u]), 1);
    chk({nm, "_start_cnt"}, int'(cnt_w[u]), 0);
    for (int t = 0; t < nbits * BC; t++) begin
      if (t % BC == BC / 2) chk($sformatf("%s_bit%0d", nm, t / BC), int'(tx_w[u]), int'(exp_bits[t / BC]));
      if (t == nbits * BC - 1) chk({nm, "_done_early"}, int'(done_w[u]), 0);
      tick();
    end
    chk({nm, "_done_pulse"}, int'(done_w[u]), 1);
    chk({nm, "_busy_end"}, int'(busy_w[u]), 0);
    chk({nm, "_tx_end"}, int'(tx_w[u]), 1);
    tick();
    chk({nm, "_done_single"}, int'(done_w[u]), 0);
  endtask

  initial begin
    int acc, first_edge, a5_edge, end_edge, maxcnt, done_cnt, full_cnt, full_rdy;
    int low_cnt, busy_cnt, dn, acc_cnt;
    bit r, timed_out;

    for (int u = 0; u < NU; u++) begin
      valid_drv[u] = 1'b0;
      data_drv[u]  = '0;
    end
    rst = 1'b1;
    tick();
    check_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_tx", int'(tx_w[0]), 1);
    chk("reset_busy", int'(busy_w[0]), 0);
    chk("reset_done", int'(done_w[0]), 0);
    chk("reset_cnt", int'(cnt_w[0]), 0);
    chk("reset_ready", int'(ready_w[0]), 1);
    tick();

    // Hand-derived line patterns, bit 0 = start bit.
    frame_check(0, 9'h055, 16'h02AA, 10, "8N1_55");
    frame_check(1, 9'h007, 16'h060E, 11, "8E1_07");
    frame_check(2, 9'h007, 16'h040E, 11, "8O1_07");
    frame_check(3, 9'h01F, 16'h00FE, 8,  "5N2_1F");

    // Six words offered back to back into a 4-deep FIFO.
    acc = 0; first_edge = -1; a5_edge = -1; maxcnt = 0; done_cnt = 0;
    full_cnt = -1; full_rdy = -1;
    valid_drv[0] = 1'b1;
    data_drv[0]  = 9'h0A0;
    for (int i = 0; i < 400 && acc < 6; i++) begin
      r = ready_w[0];
      tick();
      if (r) begin
        if (acc == 0) first_edge = cyc;
        if (acc == 5) a5_edge = cyc;
        acc++;
        data_drv[0] = 9'h0A0 + 9'(acc);
      end
      if (first_edge >= 0 && cyc == first_edge + 4) begin
        full_cnt = int'(cnt_w[0]);
        full_rdy = int'(ready_w[0]);
      end
      if (int'(cnt_w[0]) > maxcnt) maxcnt = int'(cnt_w[0]);
      if (done_w[0]) done_cnt++;
    end
    valid_drv[0] = 1'b0;
    chk("fill_accepted", acc, 6);
    chk("fill_full_cnt", full_cnt, 4);
    chk("fill_full_ready", full_rdy, 0);
    chk("fill_a5_edge", a5_edge - first_edge, 102);
    chk("fill_max_cnt", maxcnt, 4);
    end_edge = -1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (done_w[0]) done_cnt++;
      if (!busy_w[0]) begin
        end_edge = cyc;
        break;
      end
    end
    chk("fill_busy_span", end_edge - first_edge, 601);
    chk("fill_done_count", done_cnt, 6);
    tick();

    // Reset in the middle of the data bits with two words still queued.
    valid_drv[0] = 1'b1;
    data_drv[0]  = 9'h03C;
    tick();
    data_drv[0] = 9'h011;
    tick();
    data_drv[0] = 9'h022;
    tick();
    valid_drv[0] = 1'b0;
    chk("rst_mid_queued", int'(cnt_w[0]), 2);
    repeat (40) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_tx", int'(tx_w[0]), 1);
    chk("rst_mid_cnt", int'(cnt_w[0]), 0);
    chk("rst_mid_busy", int'(busy_w[0]), 0);
    chk("rst_mid_done", int'(done_w[0]), 0);
    low_cnt = 0; busy_cnt = 0; dn = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!tx_w[0]) low_cnt++;
      if (busy_w[0]) busy_cnt++;
      if (done_w[0]) dn++;
    end
    chk("rst_after_tx_low", low_cnt, 0);
    chk("rst_after_busy", busy_cnt, 0);
    chk("rst_after_done", dn, 0);

    // Random valid toggling: fixed 0xFF words, then changing words.
    acc_cnt = 0; dn = 0;
    for (int i = 0; i < 160; i++) begin
      valid_drv[0] = 1'($urandom_range(0, 1));
      data_drv[0]  = (i < 80) ? 9'h0FF : 9'($urandom_range(0, 255));
      if (valid_drv[0] && ready_w[0]) acc_cnt++;
      tick();
      if (done_w[0]) dn++;
    end
    valid_drv[0] = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!busy_w[0] && cnt_w[0] == 3'd0 && !done_w[0]) begin
        timed_out = 1'b0;
        break;
      end
      tick();
      if (done_w[0]) dn++;
    end
    chk("rand_drain_timeout", int'(timed_out), 0);
    chk("rand_done_count", dn, acc_cnt);

    repeat (3) tick();
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
